fxp_accumulator: RTL and testbench
==================================

Name: fxp_accumulator

Overview:
- Downstream consumer of the fixed-point iterative multiplier: accepts a stream of signed Qn-d.d products over a val/rdy interface and sums a programmable number of terms.
- Emits one saturated sum per group, making multiplier + accumulator a dot-product / FIR tap-sum engine.
- Same two's-complement fixed-point format in and out, so no shift is applied. The decimal position is documentation only.

Parameters:
- n, 32, data bit width (signed two's complement, d fractional bits)
- d, 16, number of fractional bits (no arithmetic effect; carried for format consistency)
- m, 8, width of the term-count input and internal counter

Ports:
- clk  input  1  single clock; all state updates on posedge
- reset  input  1  synchronous, active-low: reset==0 at a posedge clears all state
- recv_val  input  1  product valid from the multiplier
- recv_rdy  output  1  block can accept a term this cycle
- recv_msg  input  n  signed fixed-point term (multiplier send_msg)
- num_terms  input  m  terms per group; sampled only when the first term of a group is accepted; 0 treated as 1
- send_val  output  1  group sum valid
- send_rdy  input  1  downstream ready
- send_msg  output  n  saturated signed sum
- send_ovf  output  1  sticky: saturation occurred at least once in this group; valid with send_val

Behaviour:
- Transfer rule: a transfer occurs only when val && rdy at a posedge, on both ports.
- Reset (reset==0): state=IDLE, acc=0, count=0, target=0, ovf=0.
  - Output values during and after reset: recv_rdy=1 (IDLE), send_val=0, send_msg=0, send_ovf=0.
  - Reset mid-group or in DONE discards the partial or pending sum; no send occurs.
- States: IDLE, ACCUM, DONE (2-bit encoding; unused code returns to IDLE with recv_rdy=0, send_val=0).
- IDLE: recv_rdy=1, send_val=0. On a recv transfer:
  - acc<=recv_msg, count<=1, ovf<=0.
  - target<=max(num_terms,1).
  - Next state: DONE if target==1, else ACCUM.
- ACCUM: recv_rdy=1, send_val=0. On a recv transfer:
  - acc<=sat(acc+recv_msg), count<=count+1, ovf<=ovf|saturated.
  - If count+1==target, go to DONE; else stay.
  - No transfer: hold all state.
- DONE: recv_rdy=0, send_val=1, send_msg=acc, send_ovf=ovf.
  - On send_rdy: go to IDLE. acc, count and ovf keep their values until the next group's first term overwrites them.
  - send_msg stays stable while send_val=1 and send_rdy=0.
- Outputs are registered-state decodes only; no combinational path from recv_val or send_rdy to any output.
- Latency:
  - Result visible (send_val=1) in the cycle after the last term's transfer.
  - Minimum group period is target+1 cycles (target term cycles + 1 DONE cycle with send_rdy=1).
  - No overlap: the next group's first term is not accepted in DONE.
- Saturation:
  - Compute the sum at n+1 bits with sign extension.
  - If the sum exceeds 2^(n-1)-1, clamp to 0x7FFF_FFFF (n=32).
  - If the sum is below -2^(n-1), clamp to 0x8000_0000.
  - Clamping sets ovf. Accumulation continues from the clamped value.
- Counter: m bits; target up to 2^m-1 terms. count never wraps because a group ends at target.
- num_terms changes mid-group have no effect.

Test Plan:
- Single group, num_terms=3, terms 0x0001_8000 (1.5), 0x0002_4000 (2.25), 0xFFFF_0000 (-1.0), send_rdy=1 -> send_val one cycle after third transfer, send_msg=0x0002_C000 (2.75), send_ovf=0, back to IDLE next cycle.
- num_terms=0 and num_terms=1 with term 0xFFFE_8000 -> send_msg=0xFFFE_8000 one cycle after the transfer; recv_rdy=0 while in DONE.
- Positive saturation, num_terms=3, terms 0x7000_0000, 0x2000_0000, 0x8000_0000 -> second add clamps to 0x7FFF_FFFF, third gives 0xFFFF_FFFF, send_ovf=1. Negative case: 0x8000_0000 + 0xFFFF_0000 -> 0x8000_0000, ovf=1.
- Backpressure: hold send_rdy=0 for 5 cycles in DONE, toggle recv_val -> send_msg stable, recv_rdy=0, no term accepted. Release -> IDLE; the next group's first term is accepted the following cycle.
- Bubbles: recv_val gaps between terms, num_terms changed mid-group from 4 to 2 -> four terms still summed; sum correct; counts unaffected by idle cycles.
- Reset (reset=0) after 2 of 4 terms, then release and run a fresh 2-term group 0x0001_0000 + 0x0001_0000 -> outputs zero during reset; result 0x0002_0000 with no stale contribution.

Source files
------------

// File: rtl/fxp_accumulator.sv
// Saturating group accumulator for signed fixed-point products.
// Sums num_terms inputs per group and emits one clamped result per group.
module fxp_accumulator #(
    parameter int n = 32,
    parameter int d = 16,
    parameter int m = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         recv_val,
    output logic         recv_rdy,
    input  logic [n-1:0] recv_msg,
    input  logic [m-1:0] num_terms,
    output logic         send_val,
    input  logic         send_rdy,
    output logic [n-1:0] send_msg,
    output logic         send_ovf
);

    if (d >= n) begin : g_bad_frac
        $error("fractional bits must be fewer than data bits");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACCUM = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam logic [m-1:0] ONE_M   = {{(m-1){1'b0}}, 1'b1};
    localparam logic [n-1:0] SAT_MAX = {1'b0, {(n-1){1'b1}}};
    localparam logic [n-1:0] SAT_MIN = {1'b1, {(n-1){1'b0}}};

    state_t       state_q, state_d;
    logic [n-1:0] acc_q, acc_d;
    logic [m-1:0] cnt_q, cnt_d;
    logic [m-1:0] tgt_q, tgt_d;
    logic         ovf_q, ovf_d;

    logic [n:0]   sum_ext;
    logic         sat;
    logic [n-1:0] sum_sat;
    logic [m-1:0] cnt_inc;
    logic [m-1:0] tgt_first;

    // One guard bit: overflow shows up as a disagreement of the top two bits.
    assign sum_ext   = {acc_q[n-1], acc_q} + {recv_msg[n-1], recv_msg};
    assign sat       = sum_ext[n] ^ sum_ext[n-1];
    assign sum_sat   = sat ? (sum_ext[n] ? SAT_MIN : SAT_MAX)
                           : sum_ext[n-1:0];
    assign cnt_inc   = cnt_q + ONE_M;
    assign tgt_first = (num_terms == '0) ? ONE_M : num_terms;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (recv_val) begin
                    acc_d   = recv_msg;
                    cnt_d   = ONE_M;
                    ovf_d   = 1'b0;
                    tgt_d   = tgt_first;
                    state_d = (tgt_first == ONE_M) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (recv_val) begin
                    acc_d = sum_sat;
                    cnt_d = cnt_inc;
                    ovf_d = ovf_q | sat;
                    if (cnt_inc == tgt_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (send_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            tgt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign recv_rdy = (state_q == IDLE) || (state_q == ACCUM);
    assign send_val = (state_q == DONE);
    assign send_msg = acc_q;
    assign send_ovf = ovf_q;

endmodule

// File: tb/tb_fxp_accumulator.sv
// Bench for fxp_accumulator: group-level reference model plus directed
// literal checks, followed by randomized traffic with occasional resets.
module tb_fxp_accumulator;

    logic        clk = 1'b0;
    logic        reset;
    logic        recv_val;
    logic        recv_rdy;
    logic [31:0] recv_msg;
    logic [7:0]  num_terms;
    logic        send_val;
    logic        send_rdy;
    logic [31:0] send_msg;
    logic        send_ovf;

    always #5 clk = ~clk;

    fxp_accumulator #(.n(32), .d(16), .m(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .recv_val  (recv_val),
        .recv_rdy  (recv_rdy),
        .recv_msg  (recv_msg),
        .num_terms (num_terms),
        .send_val  (send_val),
        .send_rdy  (send_rdy),
        .send_msg  (send_msg),
        .send_ovf  (send_ovf)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Reference model: collects each group's terms, folds them when complete.
    bit          m_done  = 1'b0;
    bit          m_fresh = 1'b1;
    int          m_cnt   = 0;
    int          m_tgt   = 1;
    logic [31:0] m_terms[$];
    logic [31:0] m_sum   = '0;
    bit          m_ovf   = 1'b0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp,
                     $time);
        end
    endtask

    function automatic void fold();
        longint a;
        a     = longint'($signed(m_terms[0]));
        m_ovf = 1'b0;
        for (int i = 1; i < m_terms.size(); i++) begin
            a = a + longint'($signed(m_terms[i]));
            if (a > 64'sd2147483647) begin
                a     = 64'sd2147483647;
                m_ovf = 1'b1;
            end else if (a < -64'sd2147483648) begin
                a     = -64'sd2147483648;
                m_ovf = 1'b1;
            end
        end
        m_sum = a[31:0];
    endfunction

    initial forever begin
        @(posedge clk);
        if (reset === 1'b0) begin
            m_done  = 1'b0;
            m_fresh = 1'b1;
            m_cnt   = 0;
            m_terms.delete();
            m_sum   = '0;
            m_ovf   = 1'b0;
        end else if (m_done) begin
            if (send_rdy) m_done = 1'b0;
        end else if (recv_val) begin
            if (m_cnt == 0) begin
                m_tgt = (num_terms == 8'd0) ? 1 : int'(num_terms);
                m_terms.delete();
            end
            m_terms.push_back(recv_msg);
            m_cnt++;
            m_fresh = 1'b0;
            if (m_cnt == m_tgt) begin
                fold();
                m_done = 1'b1;
                m_cnt  = 0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("recv_rdy", {31'b0, recv_rdy}, {31'b0, !m_done});
            chk("send_val", {31'b0, send_val}, {31'b0, m_done});
            if (m_done || m_fresh) begin
                chk("send_msg", send_msg, m_sum);
                chk("send_ovf", {31'b0, send_ovf}, {31'b0, m_ovf});
            end
        end
    end

    task automatic step(input bit v, input logic [31:0] msg,
                        input logic [7:0] nt, input bit sr);
        @(negedge clk);
        recv_val  = v;
        recv_msg  = msg;
        num_terms = nt;
        send_rdy  = sr;
    endtask

    function automatic logic [31:0] pick_term();
        logic [31:0] s;
        s = $urandom_range(0, 32'h0007_FFFF) - 32'h0004_0000;
        case ($urandom_range(0, 3))
            0: return s;
            1: return $urandom;
            2: return 32'h7FFF_0000 + s;
            default: return 32'h8000_0000 + s;
        endcase
    endfunction

    initial begin
        reset     = 1'b0;
        recv_val  = 1'b0;
        recv_msg  = '0;
        num_terms = '0;
        send_rdy  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_rdy", {31'b0, recv_rdy}, 32'd1);
        chk("rst_val", {31'b0, send_val}, 32'd0);
        chk("rst_msg", send_msg, 32'h0);
        reset = 1'b1;

        // Three-term group: 1.5 + 2.25 - 1.0 = 2.75
        step(1, 32'h0001_8000, 8'd3, 1);
        step(1, 32'h0002_4000, 8'd3, 1);
        step(1, 32'hFFFF_0000, 8'd3, 1);
        step(0, 32'h0, 8'd3, 1);
        chk("g1_val", {31'b0, send_val}, 32'd1);
        chk("g1_msg", send_msg, 32'h0002_C000);
        chk("g1_ovf", {31'b0, send_ovf}, 32'd0);
        step(0, 32'h0, 8'd3, 1);
        chk("g1_idle", {31'b0, send_val}, 32'd0);

        // num_terms of 0 and of 1 both form single-term groups
        for (int k = 0; k < 2; k++) begin
            step(1, 32'hFFFE_8000, 8'(k), 0);
            step(0, 32'h0, 8'(k), 0);
            chk("one_val", {31'b0, send_val}, 32'd1);
            chk("one_msg", send_msg, 32'hFFFE_8000);
            chk("one_rdy", {31'b0, recv_rdy}, 32'd0);
            step(0, 32'h0, 8'(k), 1);
            step(0, 32'h0, 8'(k), 0);
            chk("one_idle", {31'b0, send_val}, 32'd0);
        end

        // Positive clamp, then continue from the clamped value
        step(1, 32'h7000_0000, 8'd3, 1);
        step(1, 32'h2000_0000, 8'd3, 1);
        step(1, 32'h8000_0000, 8'd3, 1);
        chk("sat_mid", send_msg, 32'h7FFF_FFFF);
        chk("sat_mid_ovf", {31'b0, send_ovf}, 32'd1);
        step(0, 32'h0, 8'd3, 1);
        chk("sat_pos", send_msg, 32'hFFFF_FFFF);
        chk("sat_pos_ovf", {31'b0, send_ovf}, 32'd1);
        step(0, 32'h0, 8'd2, 1);

        step(1, 32'h8000_0000, 8'd2, 1);
        step(1, 32'hFFFF_0000, 8'd2, 1);
        step(0, 32'h0, 8'd2, 1);
        chk("sat_neg", send_msg, 32'h8000_0000);
        chk("sat_neg_ovf", {31'b0, send_ovf}, 32'd1);
        step(0, 32'h0, 8'd2, 0);

        // Backpressure with recv_val toggling
        step(1, 32'h0003_0000, 8'd2, 0);
        step(1, 32'h0001_0000, 8'd2, 0);
        for (int i = 0; i < 5; i++) begin
            step(bit'(i % 2 == 0), 32'hDEAD_0000, 8'd1, 0);
            chk("bp_msg", send_msg, 32'h0004_0000);
            chk("bp_rdy", {31'b0, recv_rdy}, 32'd0);
        end
        step(1, 32'h0000_0005, 8'd1, 1);
        step(1, 32'h0000_0005, 8'd1, 1);
        chk("bp_next_rdy", {31'b0, recv_rdy}, 32'd1);
        step(0, 32'h0, 8'd1, 1);
        chk("bp_next_msg", send_msg, 32'h0000_0005);
        step(0, 32'h0, 8'd1, 1);

        // Bubbles and a mid-group num_terms change
        step(1, 32'h0001_0000, 8'd4, 1);
        step(0, 32'h0, 8'd4, 1);
        step(1, 32'h0002_0000, 8'd2, 1);
        step(0, 32'h0, 8'd2, 1);
        step(0, 32'h0, 8'd2, 1);
        step(1, 32'h0003_0000, 8'd2, 1);
        step(0, 32'h0, 8'd2, 1);
        chk("bub_wait", {31'b0, send_val}, 32'd0);
        step(1, 32'h0004_0000, 8'd2, 1);
        step(0, 32'h0, 8'd2, 1);
        chk("bub_val", {31'b0, send_val}, 32'd1);
        chk("bub_msg", send_msg, 32'h000A_0000);
        step(0, 32'h0, 8'd2, 1);

        // Reset mid-group discards the partial sum
        step(1, 32'h0001_0000, 8'd4, 1);
        step(1, 32'h0001_0000, 8'd4, 1);
        step(0, 32'h0, 8'd4, 1);
        reset = 1'b0;
        step(0, 32'h0, 8'd4, 1);
        chk("mrst_msg", send_msg, 32'h0);
        chk("mrst_val", {31'b0, send_val}, 32'd0);
        chk("mrst_rdy", {31'b0, recv_rdy}, 32'd1);
        reset = 1'b1;
        step(1, 32'h0001_0000, 8'd2, 1);
        step(1, 32'h0001_0000, 8'd2, 1);
        step(0, 32'h0, 8'd2, 1);
        chk("post_rst_msg", send_msg, 32'h0002_0000);
        step(0, 32'h0, 8'd2, 1);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            reset     = ($urandom_range(0, 299) != 0);
            recv_val  = ($urandom_range(0, 9) < 7);
            recv_msg  = pick_term();
            num_terms = ($urandom_range(0, 39) == 0) ?
                        8'($urandom_range(0, 255)) :
                        8'($urandom_range(0, 6));
            send_rdy  = ($urandom_range(0, 9) < 6);
        end
        @(negedge clk);
        reset    = 1'b1;
        recv_val = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
